// File: rtl/multi_region_tracker.sv
// multi_region_tracker: per-slice target-color pixel counter with thresholding, frame debounce and strongest-region pick.
// Ports: clk, rst_n (async, active-low); pix_valid/x/y/eh_verde pixel stream in;
// detected (debounced per-region flags), winner_idx/winner_valid/best_count (strongest hit region of last frame),
// frame_done (pulse when outputs update), overrun (pulse when an end of frame aborts a scan in progress).
module multi_region_tracker #(
  parameter int N_REGIONS   = 4,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int X_W         = 10,
  parameter int CNT_W       = 16,
  parameter int THRESHOLD   = 20,
  parameter int HYST_FRAMES = 2,
  parameter int IDX_W       = $clog2(N_REGIONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_valid,
  input  logic [X_W-1:0]       x,
  input  logic [X_W-1:0]       y,
  input  logic                 eh_verde,
  output logic [N_REGIONS-1:0] detected,
  output logic [IDX_W-1:0]     winner_idx,
  output logic                 winner_valid,
  output logic [CNT_W-1:0]     best_count,
  output logic                 frame_done,
  output logic                 overrun
);
  localparam int REGION_W = WIDTH / N_REGIONS;
  localparam int ST_W = $clog2(HYST_FRAMES + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_SCAN = 2'd1, S_PUB = 2'd2;
  logic [N_REGIONS-1:0][CNT_W-1:0] live_q, live_d, snap_q, snap_d;
  logic [N_REGIONS-1:0][ST_W-1:0] streak_q, streak_d, streak_sh_q, streak_sh_d;
  logic [N_REGIONS-1:0] det_q, det_d, det_sh_q, det_sh_d;
  logic [1:0] state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d, best_idx_q, best_idx_d, win_idx_q, win_idx_d;
  logic best_vld_q, best_vld_d, win_vld_q, win_vld_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d, win_cnt_q, win_cnt_d;
  logic frame_done_q, frame_done_d, overrun_q, overrun_d;
  logic [31:0] xi, yi;
  logic in_frame, sof, eof, hit;
  logic [CNT_W-1:0] cur;
  assign xi = 32'(x);
  assign yi = 32'(y);
  assign in_frame = pix_valid && xi < 32'(WIDTH) && yi < 32'(HEIGHT);
  assign sof = in_frame && xi == 32'd0 && yi == 32'd0;
  assign eof = in_frame && xi == 32'(WIDTH - 1) && yi == 32'(HEIGHT - 1);
  assign cur = snap_q[k_q];
  assign hit = 32'(cur) > 32'(THRESHOLD);
  // The EOF pixel is counted before the snapshot is taken, so live_d is reused as the post-pixel count.
  always_comb begin
    live_d = live_q;
    snap_d = snap_q;
    for (int k = 0; k < N_REGIONS; k++) begin
      live_d[k] = sof ? '0 : live_q[k];
      if (in_frame && eh_verde && xi >= 32'(k * REGION_W) && xi < 32'((k + 1) * REGION_W) && live_d[k] != '1)
        live_d[k] = live_d[k] + 1'b1;
      if (eof) begin
        snap_d[k] = live_d[k];
        live_d[k] = '0;
      end
    end
  end
  // Scan results accumulate in shadows; an EOF mid-scan reverts them to the committed flags/streaks.
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    best_idx_d = best_idx_q;
    best_vld_d = best_vld_q;
    best_cnt_d = best_cnt_q;
    win_idx_d = win_idx_q;
    win_vld_d = win_vld_q;
    win_cnt_d = win_cnt_q;
    det_d = det_q;
    streak_d = streak_q;
    det_sh_d = det_sh_q;
    streak_sh_d = streak_sh_q;
    frame_done_d = 1'b0;
    overrun_d = 1'b0;
    if (eof) begin
      state_d = S_SCAN;
      k_d = '0;
      best_idx_d = '0;
      best_vld_d = 1'b0;
      best_cnt_d = '0;
      det_sh_d = det_q;
      streak_sh_d = streak_q;
      overrun_d = state_q != S_IDLE;
    end else if (state_q == S_SCAN) begin
      if (hit && (!best_vld_q || cur > best_cnt_q)) begin
        best_idx_d = k_q;
        best_vld_d = 1'b1;
        best_cnt_d = cur;
      end
      if (hit == det_sh_q[k_q]) begin
        streak_sh_d[k_q] = '0;
      end else if (streak_sh_q[k_q] == ST_W'(HYST_FRAMES - 1)) begin
        streak_sh_d[k_q] = '0;
        det_sh_d[k_q] = ~det_sh_q[k_q];
      end else begin
        streak_sh_d[k_q] = streak_sh_q[k_q] + 1'b1;
      end
      k_d = k_q + 1'b1;
      state_d = (k_q == IDX_W'(N_REGIONS - 1)) ? S_PUB : S_SCAN;
    end else if (state_q == S_PUB) begin
      win_idx_d = best_idx_q;
      win_vld_d = best_vld_q;
      win_cnt_d = best_cnt_q;
      det_d = det_sh_q;
      streak_d = streak_sh_q;
      frame_done_d = 1'b1;
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= '0;
      snap_q <= '0;
      streak_q <= '0;
      streak_sh_q <= '0;
      det_q <= '0;
      det_sh_q <= '0;
      state_q <= S_IDLE;
      k_q <= '0;
      best_idx_q <= '0;
      best_vld_q <= 1'b0;
      best_cnt_q <= '0;
      win_idx_q <= '0;
      win_vld_q <= 1'b0;
      win_cnt_q <= '0;
      frame_done_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      live_q <= live_d;
      snap_q <= snap_d;
      streak_q <= streak_d;
      streak_sh_q <= streak_sh_d;
      det_q <= det_d;
      det_sh_q <= det_sh_d;
      state_q <= state_d;
      k_q <= k_d;
      best_idx_q <= best_idx_d;
      best_vld_q <= best_vld_d;
      best_cnt_q <= best_cnt_d;
      win_idx_q <= win_idx_d;
      win_vld_q <= win_vld_d;
      win_cnt_q <= win_cnt_d;
      frame_done_q <= frame_done_d;
      overrun_q <= overrun_d;
    end
  end
  assign detected = det_q;
  assign winner_idx = win_idx_q;
  assign winner_valid = win_vld_q;
  assign best_count = win_cnt_q;
  assign frame_done = frame_done_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_multi_region_tracker.sv
// tb_multi_region_tracker: randomized and directed stimulus checked every cycle against a frame-level model.
module tb_multi_region_tracker;
  localparam int N = 4, W = 16, H = 4, RW = 4, THR = 5, HY = 2, CW = 4, XW = 5, CMAX = 15;
  logic clk = 1'b0, rst_n = 1'b0, pix_valid = 1'b0, eh_verde = 1'b0;
  logic [XW-1:0] x = '0, y = '0;
  logic [N-1:0] detected;
  logic [1:0] winner_idx;
  logic winner_valid, frame_done, overrun;
  logic [CW-1:0] best_count;
  int errors = 0, checks = 0;
  bit rnd_gaps = 1'b0;
  bit g[H][20];
  always #5 clk = ~clk;
  multi_region_tracker #(.N_REGIONS(N), .WIDTH(W), .HEIGHT(H), .X_W(XW), .CNT_W(CW),
    .THRESHOLD(THR), .HYST_FRAMES(HY)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .x(x), .y(y), .eh_verde(eh_verde),
    .detected(detected), .winner_idx(winner_idx), .winner_valid(winner_valid),
    .best_count(best_count), .frame_done(frame_done), .overrun(overrun));
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Frame-level model: live counts per region, committed outputs, and one pending frame result.
  int ml[N], ms[N], ps[N];
  bit md[N], pd[N];
  int pw, pb, ow, ob, due, cyc;
  bit pv, ov, pend, efd, eov;
  task automatic frame_eval();
    int mx;
    mx = -1;
    pw = 0;
    for (int r = 0; r < N; r++) begin
      bit hit;
      hit = ml[r] > THR;
      if (hit && ml[r] > mx) begin
        mx = ml[r];
        pw = r;
      end
      if (hit == md[r]) begin
        pd[r] = md[r];
        ps[r] = 0;
      end else if (ms[r] + 1 >= HY) begin
        pd[r] = !md[r];
        ps[r] = 0;
      end else begin
        pd[r] = md[r];
        ps[r] = ms[r] + 1;
      end
    end
    pv = mx >= 0;
    pb = pv ? mx : 0;
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        ml[r] = 0;
        md[r] = 0;
        ms[r] = 0;
      end
      pend = 0; cyc = 0; efd = 0; eov = 0; ow = 0; ov = 0; ob = 0;
    end else begin
      efd = 0;
      eov = 0;
      if (pix_valid && x < W && y < H) begin
        if (x == 0 && y == 0)
          for (int r = 0; r < N; r++) ml[r] = 0;
        if (eh_verde && x < N * RW && ml[x / RW] < CMAX) ml[x / RW]++;
      end
      if (pix_valid && x == W - 1 && y == H - 1) begin
        eov = pend;
        frame_eval();
        pend = 1;
        due = cyc + N + 1;
        for (int r = 0; r < N; r++) ml[r] = 0;
      end else if (pend && cyc == due) begin
        for (int r = 0; r < N; r++) begin
          md[r] = pd[r];
          ms[r] = ps[r];
        end
        ow = pw; ov = pv; ob = pb;
        efd = 1;
        pend = 0;
      end
      cyc++;
    end
  end
  always @(negedge clk) begin
    chk("detected", int'(detected), int'({md[3], md[2], md[1], md[0]}));
    chk("winner_idx", int'(winner_idx), ow);
    chk("winner_valid", int'(winner_valid), int'(ov));
    chk("best_count", int'(best_count), ob);
    chk("frame_done", int'(frame_done), int'(efd));
    chk("overrun", int'(overrun), int'(eov));
  end
  task automatic pix(bit v, int xx, int yy, bit e);
    pix_valid = v;
    x = XW'(xx);
    y = XW'(yy);
    eh_verde = e;
    @(posedge clk);
    #1;
  endtask
  task automatic gap();
    while (rnd_gaps && $urandom_range(0, 4) == 0)
      pix(1'b0, $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom));
  endtask
  task automatic frame(bit extra);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < ((extra && yy < H - 1) ? 20 : W); xx++) begin
        gap();
        pix(1'b1, xx, yy, g[yy][xx]);
      end
    pix_valid = 1'b0;
  endtask
  task automatic clr();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < 20; xx++) g[yy][xx] = 1'b0;
  endtask
  task automatic add(int r, int n);
    for (int i = 0; i < n; i++) g[i / RW][r * RW + i % RW] = 1'b1;
  endtask
  task automatic wait_fd(output int lat);
    lat = -1;
    pix_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) begin
        lat = i;
        break;
      end
    end
  endtask
  initial begin
    int lat;
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int lat;
    clr();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_detected", int'(detected), 0);
    chk("rst_winner_valid", int'(winner_valid), 0);
    chk("rst_best_count", int'(best_count), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    frame(0);
    wait_fd(lat);
    chk("idle_latency", lat, 5);
    chk("idle_winner_valid", int'(winner_valid), 0);
    chk("idle_best", int'(best_count), 0);
    rnd_gaps = 1'b1;
    clr();
    add(2, 8);
    frame(0);
    wait_fd(lat);
    chk("deb1_idx", int'(winner_idx), 2);
    chk("deb1_best", int'(best_count), 8);
    chk("deb1_det", int'(detected), 0);
    frame(0);
    wait_fd(lat);
    chk("deb2_det", int'(detected), 4);
    clr();
    frame(0);
    wait_fd(lat);
    chk("off1_det", int'(detected), 4);
    frame(0);
    wait_fd(lat);
    chk("off2_det", int'(detected), 0);
    clr();
    add(0, 7);
    add(3, 7);
    add(1, 5);
    frame(0);
    wait_fd(lat);
    chk("tie_idx", int'(winner_idx), 0);
    chk("tie_best", int'(best_count), 7);
    frame(0);
    wait_fd(lat);
    chk("tie_det", int'(detected), 9);
    clr();
    add(1, 16);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 16; xx < 20; xx++) g[yy][xx] = 1'b1;
    frame(1);
    wait_fd(lat);
    chk("sat_idx", int'(winner_idx), 1);
    chk("sat_best", int'(best_count), 15);
    chk("sat_det", int'(detected), 9);
    clr();
    add(2, 8);
    rnd_gaps = 1'b0;
    frame(0);
    chk("ovr_no_fd_a", int'(frame_done), 0);
    pix(1'b0, 0, 0, 1'b0);
    chk("ovr_no_fd_b", int'(frame_done), 0);
    pix(1'b1, W - 1, H - 1, 1'b1);
    chk("ovr_pulse", int'(overrun), 1);
    wait_fd(lat);
    chk("ovr_latency", lat, 5);
    chk("ovr_winner_valid", int'(winner_valid), 0);
    chk("ovr_best", int'(best_count), 0);
    clr();
    add(0, 8);
    frame(0);
    wait_fd(lat);
    frame(0);
    wait_fd(lat);
    chk("mrst_pre_det", int'(detected), 1);
    for (int yy = 0; yy < 2; yy++)
      for (int xx = 0; xx < W; xx++) pix(1'b1, xx, yy, g[yy][xx]);
    #3 rst_n = 1'b0;
    #1 chk("mrst_async_det", int'(detected), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame(0);
    wait_fd(lat);
    chk("mrst_idx", int'(winner_idx), 0);
    chk("mrst_best", int'(best_count), 8);
    chk("mrst_det", int'(detected), 0);
    rnd_gaps = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int dens[N];
      for (int r = 0; r < N; r++) dens[r] = $urandom_range(0, 16);
      for (int yy = 0; yy < H; yy++)
        for (int xx = 0; xx < 20; xx++)
          g[yy][xx] = (xx >= N * RW) ? 1'($urandom) : ($urandom_range(0, 15) < dens[xx / RW]);
      frame(1'($urandom_range(0, 3) == 0));
      for (int i = $urandom_range(0, 8); i > 0; i--)
        if ($urandom_range(0, 9) == 0) pix(1'b1, W - 1, H - 1, 1'($urandom));
        else pix(1'b0, 0, 0, 1'b0);
    end
    pix_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
